// File: rtl/draw_bus_receiver.sv
// rtl/draw_bus_receiver.sv - pixel bus receiver: queues pixel strobes, converts colour,
// writes the shared framebuffer through a request/grant port, and runs full-screen clears.
module draw_bus_receiver #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int DEPTH       = 16,
    parameter int COLOUR_BITS = 9,
    parameter int ADDR_BITS   = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   draw_enable,
    input  logic [7:0]             x_in,
    input  logic [7:0]             y_in,
    input  logic [23:0]            rgb_in,
    input  logic                   clear,
    input  logic [COLOUR_BITS-1:0] clear_colour,
    input  logic                   fb_grant,
    output logic                   fb_write_enable,
    output logic [ADDR_BITS-1:0]   fb_address,
    output logic [COLOUR_BITS-1:0] fb_data,
    output logic                   busy,
    output logic                   clear_done,
    output logic                   overflow,
    output logic                   out_of_range
);

    localparam int C          = COLOUR_BITS / 3;
    localparam int PTR_BITS   = $clog2(DEPTH);
    localparam int ENTRY_BITS = ADDR_BITS + COLOUR_BITS;

    localparam logic [8:0]           WIDTH_L    = 9'(WIDTH);
    localparam logic [8:0]           HEIGHT_L   = 9'(HEIGHT);
    localparam logic [ADDR_BITS-1:0] WIDTH_A    = ADDR_BITS'(WIDTH);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(WIDTH * HEIGHT - 1);
    localparam logic [PTR_BITS:0]    FULL_COUNT = (PTR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ENTRY_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [PTR_BITS:0]     count;

    logic                   clear_pending;
    logic [COLOUR_BITS-1:0] clear_colour_q;
    logic [ADDR_BITS-1:0]   clr_addr;
    logic                   clr_issued_all;

    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   in_range;
    logic [ADDR_BITS-1:0]   pixel_addr;
    logic [COLOUR_BITS-1:0] pixel_colour;
    logic [ENTRY_BITS-1:0]  head_entry;
    logic                   port_ready;
    logic                   write_done;
    logic                   accept_clear;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   clear_issue;
    logic                   clear_finish;

    // Low-order colour bits are intentionally truncated away.
    logic unused_rgb_bits;
    assign unused_rgb_bits = ^{rgb_in[23-C:16], rgb_in[15-C:8], rgb_in[7-C:0]};

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == FULL_COUNT);
    assign in_range     = ({1'b0, x_in} < WIDTH_L) && ({1'b0, y_in} < HEIGHT_L);
    assign pixel_addr   = ADDR_BITS'(y_in) * WIDTH_A + ADDR_BITS'(x_in);
    assign pixel_colour = {rgb_in[23 -: C], rgb_in[15 -: C], rgb_in[7 -: C]};
    assign head_entry   = mem[rd_ptr];

    // The port can take a new write when empty or when its current write completes this edge.
    assign port_ready = !fb_write_enable || fb_grant;
    assign write_done = fb_write_enable && fb_grant;

    always_comb begin
        state_next   = state;
        accept_clear = 1'b0;
        pop          = 1'b0;
        clear_issue  = 1'b0;
        clear_finish = 1'b0;
        case (state)
            S_IDLE, S_DRAIN: begin
                accept_clear = (clear || clear_pending) && port_ready;
                pop          = !accept_clear && !fifo_empty && port_ready;
                if (accept_clear) begin
                    state_next = S_CLEAR;
                end else if (state == S_IDLE) begin
                    if (!fifo_empty) state_next = S_DRAIN;
                end else if (fifo_empty && !fb_write_enable) begin
                    state_next = S_IDLE;
                end
            end
            S_CLEAR: begin
                clear_issue  = port_ready && !clr_issued_all;
                clear_finish = clr_issued_all && write_done;
                if (clear_finish) state_next = fifo_empty ? S_IDLE : S_DRAIN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign push = draw_enable && in_range && (!fifo_full || pop);
    assign drop = draw_enable && in_range && fifo_full && !pop;

    assign busy = (state != S_IDLE) || !fifo_empty || fb_write_enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pixel_addr, pixel_colour};
    end

    // Accepting a clear discards everything queued, including a pixel captured on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (accept_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow     <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            if (drop)                     overflow     <= 1'b1;
            if (draw_enable && !in_range) out_of_range <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_pending  <= 1'b0;
            clear_colour_q <= '0;
            clr_addr       <= '0;
            clr_issued_all <= 1'b0;
            clear_done     <= 1'b0;
        end else begin
            clear_done <= clear_finish;
            if (accept_clear) begin
                clear_pending  <= 1'b0;
                clear_colour_q <= clear_colour;
                clr_addr       <= '0;
                clr_issued_all <= 1'b0;
            end else if (clear && state == S_DRAIN) begin
                clear_pending <= 1'b1;
            end
            if (clear_issue) begin
                clr_addr <= clr_addr + 1'b1;
                if (clr_addr == LAST_ADDR) clr_issued_all <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_write_enable <= 1'b0;
            fb_address      <= '0;
            fb_data         <= '0;
        end else if (pop) begin
            fb_write_enable <= 1'b1;
            fb_address      <= head_entry[ENTRY_BITS-1:COLOUR_BITS];
            fb_data         <= head_entry[COLOUR_BITS-1:0];
        end else if (clear_issue) begin
            fb_write_enable <= 1'b1;
            fb_address      <= clr_addr;
            fb_data         <= clear_colour_q;
        end else if (write_done) begin
            fb_write_enable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_draw_bus_receiver.sv
// tb/tb_draw_bus_receiver.sv - directed scoreboard bench for draw_bus_receiver.
module tb_draw_bus_receiver;

    logic        clk;
    logic        reset;
    logic        draw_enable;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic [23:0] rgb_in;
    logic        clear;
    logic [8:0]  clear_colour;
    logic        fb_grant;
    logic        fb_write_enable;
    logic [14:0] fb_address;
    logic [8:0]  fb_data;
    logic        busy;
    logic        clear_done;
    logic        overflow;
    logic        out_of_range;

    int n_checks;
    int n_fail;
    int writes_seen;
    int done_seen;

    logic [23:0] sb [$];

    draw_bus_receiver dut (
        .clk(clk), .reset(reset), .draw_enable(draw_enable), .x_in(x_in), .y_in(y_in),
        .rgb_in(rgb_in), .clear(clear), .clear_colour(clear_colour), .fb_grant(fb_grant),
        .fb_write_enable(fb_write_enable), .fb_address(fb_address), .fb_data(fb_data),
        .busy(busy), .clear_done(clear_done), .overflow(overflow), .out_of_range(out_of_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_word(input int x, input int y, input logic [23:0] rgb);
        return {15'(y * 160 + x), rgb[23:21], rgb[15:13], rgb[7:5]};
    endfunction

    // Any pending write must show the scoreboard head; it is retired on a granted cycle.
    task automatic tick();
        logic [23:0] exp;
        @(negedge clk);
        if (fb_write_enable) begin
            exp = (sb.size() > 0) ? sb[0] : 24'hFFFFFF;
            check("write", 32'({fb_address, fb_data}), 32'(exp));
            if (fb_grant) begin
                if (sb.size() > 0) void'(sb.pop_front());
                writes_seen++;
            end
        end
        if (clear_done) done_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && busy; i++) tick();
        check(tag, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic pixel(input int x, input int y, input logic [23:0] rgb, input bit expect_write);
        draw_enable = 1'b1;
        x_in        = 8'(x);
        y_in        = 8'(y);
        rgb_in      = rgb;
        if (expect_write) sb.push_back(exp_word(x, y, rgb));
        tick();
        draw_enable = 1'b0;
    endtask

    initial begin
        int w0;
        int d0;
        logic [23:0] rgb;
        n_checks = 0; n_fail = 0; writes_seen = 0; done_seen = 0;
        reset = 1'b1; draw_enable = 1'b0; x_in = '0; y_in = '0; rgb_in = '0;
        clear = 1'b0; clear_colour = '0; fb_grant = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", 32'(fb_write_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_oor", 32'(out_of_range), 32'd0);
        check("rst_done", 32'(clear_done), 32'd0);
        reset = 1'b0;
        tick();

        // Single pixel: captured at edge N, request after N+1, completes at N+2.
        fb_grant = 1'b1;
        w0 = writes_seen;
        pixel(3, 2, 24'hFF8040, 1'b1);
        check("lat_we_n", 32'(fb_write_enable), 32'd0);
        check("lat_busy_n", 32'(busy), 32'd1);
        tick();
        check("lat_we_n1", 32'(fb_write_enable), 32'd1);
        check("lat_addr", 32'(fb_address), 32'd323);
        check("lat_data", 32'(fb_data), 32'h1E2);
        tick();
        check("lat_we_n2", 32'(fb_write_enable), 32'd0);
        check("single_count", 32'(writes_seen - w0), 32'd1);
        wait_idle("single_idle");

        // Burst of 20 with grant low: one entry reaches the port, 16 fill the queue, 3 drop.
        fb_grant = 1'b0;
        w0 = writes_seen;
        for (int i = 0; i < 20; i++) begin
            rgb = 24'($urandom);
            pixel(i, i + 1, rgb, i < 17);
        end
        repeat (10) tick();
        check("burst_ovf", 32'(overflow), 32'd1);
        fb_grant = 1'b1;
        tick();
        wait_idle("burst_idle");
        check("burst_count", 32'(writes_seen - w0), 32'd17);

        // Out-of-range pixels are discarded; the far corner is the last legal address.
        check("oor_pre", 32'(out_of_range), 32'd0);
        pixel(160, 0, 24'h123456, 1'b0);
        check("oor_busy_x", 32'(busy), 32'd0);
        pixel(0, 120, 24'h654321, 1'b0);
        check("oor_busy_y", 32'(busy), 32'd0);
        check("oor_flag", 32'(out_of_range), 32'd1);
        pixel(159, 119, 24'hA0E020, 1'b1);
        tick();
        wait_idle("corner_idle");

        // Grant toggling: pending writes hold while ungranted.
        w0 = writes_seen;
        for (int i = 0; i < 4; i++) begin
            fb_grant = i[0];
            pixel(10 + i, 50, 24'($urandom), 1'b1);
        end
        for (int i = 0; i < 40 && busy; i++) begin
            fb_grant = ~fb_grant;
            tick();
        end
        fb_grant = 1'b1;
        wait_idle("toggle_idle");
        check("toggle_count", 32'(writes_seen - w0), 32'd4);

        // Full clear with a pixel strobed mid-clear that must land after the clear.
        w0 = writes_seen;
        d0 = done_seen;
        clear = 1'b1;
        clear_colour = 9'h1C3;
        for (int a = 0; a < 19200; a++) sb.push_back({15'(a), 9'h1C3});
        tick();
        clear = 1'b0;
        repeat (100) tick();
        clear = 1'b1;
        pixel(5, 7, 24'h00FF00, 1'b1);
        clear = 1'b0;
        for (int i = 0; i < 21000 && done_seen == d0; i++) tick();
        check("clear_done_seen", 32'(done_seen - d0), 32'd1);
        wait_idle("clear_idle");
        check("clear_count", 32'(writes_seen - w0), 32'd19201);
        check("clear_done_pulse", 32'(done_seen - d0), 32'd1);
        check("clear_sticky_ovf", 32'(overflow), 32'd1);

        // Reset in the middle of a clear.
        d0 = done_seen;
        clear = 1'b1;
        clear_colour = 9'h0AA;
        for (int a = 0; a < 19200; a++) sb.push_back({15'(a), 9'h0AA});
        tick();
        clear = 1'b0;
        repeat (50) tick();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(fb_write_enable), 32'd0);
        check("mid_rst_addr", 32'(fb_address), 32'd0);
        check("mid_rst_data", 32'(fb_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_we", 32'(fb_write_enable), 32'd0);
        check("post_rst_done", 32'(done_seen - d0), 32'd0);
        pixel(0, 0, 24'hFFFFFF, 1'b1);
        tick();
        wait_idle("post_rst_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
